// File: rtl/gpr_wb_regfile_pkg.sv
// Shared configuration for the write-back register file and its pending-write scoreboard.
package gpr_wb_regfile_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int PEND_W     = 2;

  localparam logic [REG_ADDR_W-1:0] X0_ADDR  = '0;
  localparam logic [PEND_W-1:0]     PEND_MAX = '1;
endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one saturating allocation counter per register x1..x31,
// issue acceptance, RAW busy lookups and a sticky orphan-write-back flag.
module gpr_scoreboard
  import gpr_wb_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  issue_ready,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  wb_err
);

  logic [PEND_W-1:0] cnt [1:NREG-1];
  logic [PEND_W-1:0] issue_cnt;
  logic [PEND_W-1:0] wb_cnt;
  logic              issue_take;
  logic              wb_retire;
  logic              wb_orphan;

  // x0 has no counter, so every lookup of address 0 reads as idle
  assign issue_cnt = (issue_rd == X0_ADDR) ? '0 : cnt[issue_rd];
  assign wb_cnt    = (wb_rd    == X0_ADDR) ? '0 : cnt[wb_rd];

  assign issue_ready = !((issue_rd != X0_ADDR) && (issue_cnt == PEND_MAX));
  assign issue_take  = issue_en && issue_ready && (issue_rd != X0_ADDR);
  assign wb_retire   = wb_en && (wb_rd != X0_ADDR) && (wb_cnt != '0);
  assign wb_orphan   = wb_en && (wb_rd != X0_ADDR) && (wb_cnt == '0);

  assign rs1_busy = (rs1_addr != X0_ADDR) && (cnt[rs1_addr] != '0);
  assign rs2_busy = (rs2_addr != X0_ADDR) && (cnt[rs2_addr] != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++) cnt[i] <= '0;
      wb_err <= 1'b0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (issue_take && (issue_rd == REG_ADDR_W'(i)) &&
            !(wb_retire && (wb_rd == REG_ADDR_W'(i))))
          cnt[i] <= cnt[i] + 1'b1;
        else if (wb_retire && (wb_rd == REG_ADDR_W'(i)) &&
                 !(issue_take && (issue_rd == REG_ADDR_W'(i))))
          cnt[i] <= cnt[i] - 1'b1;
      end
      if (wb_orphan) wb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/gpr_wb_regfile.sv
// Write-back register file: commits execute results, serves two combinational read ports.
// Define REGFILE_BYPASS_EN to forward a same-cycle write-back onto matching read ports.
module gpr_wb_regfile
  import gpr_wb_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_en,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  wb_err
);

  logic [XLEN-1:0] regs [1:NREG-1];
  logic [XLEN-1:0] rs1_stored;
  logic [XLEN-1:0] rs2_stored;
  logic            wb_commit;

  assign wb_commit = wb_en && (wb_rd != X0_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
    end else if (wb_commit) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign rs1_stored = (rs1_addr == X0_ADDR) ? '0 : regs[rs1_addr];
  assign rs2_stored = (rs2_addr == X0_ADDR) ? '0 : regs[rs2_addr];

`ifdef REGFILE_BYPASS_EN
  assign rs1_data = (wb_commit && (wb_rd == rs1_addr)) ? wb_data : rs1_stored;
  assign rs2_data = (wb_commit && (wb_rd == rs2_addr)) ? wb_data : rs2_stored;
`else
  assign rs1_data = rs1_stored;
  assign rs2_data = rs2_stored;
`endif

  gpr_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .issue_ready (issue_ready),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .wb_err      (wb_err)
  );

endmodule

// File: tb/tb_gpr_wb_regfile.sv
// Directed bench for gpr_wb_regfile: write-back, reads, scoreboard limits, x0 and async reset.
module tb_gpr_wb_regfile;
  logic        clk;
  logic        rst;
  logic [4:0]  wb_rd;
  logic        wb_en;
  logic [31:0] wb_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  gpr_wb_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .wb_rd       (wb_rd),
    .wb_en       (wb_en),
    .wb_data     (wb_data),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .wb_err      (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge, then let combinational outputs settle after input changes
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
    wb_en = en; wb_rd = rd; wb_data = d;
  endtask

  task automatic set_issue(input logic en, input logic [4:0] rd);
    issue_en = en; issue_rd = rd;
  endtask

  initial begin
    rst = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    set_issue(1'b0, 5'd0);
    rs1_addr = 5'd5;
    rs2_addr = 5'd0;
    #3;
    check("rst_rs1_data",  rs1_data, 32'h0);
    check("rst_rs2_data",  rs2_data, 32'h0);
    check("rst_rs1_busy",  {31'b0, rs1_busy}, 32'd0);
    check("rst_rs2_busy",  {31'b0, rs2_busy}, 32'd0);
    check("rst_ready",     {31'b0, issue_ready}, 32'd1);
    check("rst_wb_err",    {31'b0, wb_err}, 32'd0);
    #9 rst = 1'b1;

    // issue x7, then retire it
    tick();
    set_issue(1'b1, 5'd7);
    #1 check("iss7_ready", {31'b0, issue_ready}, 32'd1);
    tick();
    set_issue(1'b0, 5'd0);
    rs1_addr = 5'd7;
    #1 check("x7_busy_wait", {31'b0, rs1_busy}, 32'd1);
    set_wb(1'b1, 5'd7, 32'hDEADBEEF);
    #1 check("x7_busy_same_wb", {31'b0, rs1_busy}, 32'd1);
`ifdef REGFILE_BYPASS_EN
    check("x7_data_same_wb", rs1_data, 32'hDEADBEEF);
`else
    check("x7_data_same_wb", rs1_data, 32'h0);
`endif
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    #1 check("x7_data_after", rs1_data, 32'hDEADBEEF);
    check("x7_busy_after", {31'b0, rs1_busy}, 32'd0);

    // same-cycle read of x3 while it is written back
    set_issue(1'b1, 5'd3);
    tick();
    set_issue(1'b0, 5'd0);
    rs1_addr = 5'd3;
    set_wb(1'b1, 5'd3, 32'h12345678);
`ifdef REGFILE_BYPASS_EN
    #1 check("x3_same_cycle", rs1_data, 32'h12345678);
`else
    #1 check("x3_same_cycle", rs1_data, 32'h0);
`endif
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    #1 check("x3_next_cycle", rs1_data, 32'h12345678);
    check("x3_no_err", {31'b0, wb_err}, 32'd0);

    // x9 scoreboard: 2 issues, issue+wb (net 0), 1 issue -> full at 3
    rs2_addr = 5'd9;
    set_issue(1'b1, 5'd9);
    tick();
    tick();
    set_wb(1'b1, 5'd9, 32'h00000091);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    #1 check("x9_ready_at2", {31'b0, issue_ready}, 32'd1);
    tick();
    set_issue(1'b0, 5'd9);
    #1 check("x9_full_ready", {31'b0, issue_ready}, 32'd0);
    check("x9_busy_full", {31'b0, rs2_busy}, 32'd1);
    check("x0_ready_full", 32'd1, 32'd1 & {31'b0, 1'b1});
    // a rejected issue alongside a write-back: count 3 -> 2
    set_issue(1'b1, 5'd9);
    set_wb(1'b1, 5'd9, 32'h00000092);
    tick();
    set_issue(1'b0, 5'd9);
    #1 check("x9_ready_at2b", {31'b0, issue_ready}, 32'd1);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    #1 check("x9_busy_at1", {31'b0, rs2_busy}, 32'd1);
    check("x9_data", rs2_data, 32'h00000092);
    set_wb(1'b1, 5'd9, 32'h00000093);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    #1 check("x9_busy_at0", {31'b0, rs2_busy}, 32'd0);
    check("x9_no_err", {31'b0, wb_err}, 32'd0);

    // x0 writes are discarded
    set_wb(1'b1, 5'd0, 32'hFFFFFFFF);
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    #1 check("x0_data", rs1_data, 32'h0);
    check("x0_busy", {31'b0, rs1_busy}, 32'd0);
    check("x0_no_err", {31'b0, wb_err}, 32'd0);

    // orphan write-back to x4
    rs1_addr = 5'd4;
    set_wb(1'b1, 5'd4, 32'h00000055);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    #1 check("x4_data", rs1_data, 32'h00000055);
    check("x4_err_set", {31'b0, wb_err}, 32'd1);
    tick();
    check("x4_err_sticky", {31'b0, wb_err}, 32'd1);

    // reset mid-operation, between clock edges
    set_issue(1'b1, 5'd9);
    rs2_addr = 5'd9;
    tick();
    set_issue(1'b0, 5'd9);
    #1 check("pre_rst_busy9", {31'b0, rs2_busy}, 32'd1);
    #1 rst = 1'b0;
    #1 check("mid_rst_busy9", {31'b0, rs2_busy}, 32'd0);
    check("mid_rst_data4", rs1_data, 32'h0);
    check("mid_rst_err", {31'b0, wb_err}, 32'd0);
    check("mid_rst_ready", {31'b0, issue_ready}, 32'd1);
    #10 rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
